// File: rtl/mem_port_arbiter.sv
// Shares a single-port, 1-cycle-latency RAM between the instruction fetch port and
// the data bus port. Optional performance counters are enabled with MEM_ARB_PERF_EN.
module mem_port_arbiter #(
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned RoundRobin  = 0,
    parameter int unsigned StarveLimit = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   instr_req_i,
    input  logic [AddrWidth-1:0]   instr_addr_i,
    output logic                   instr_gnt_o,
    output logic                   instr_rvalid_o,
    output logic [DataWidth-1:0]   instr_rdata_o,
    input  logic                   data_req_i,
    input  logic                   data_we_i,
    input  logic [DataWidth/8-1:0] data_be_i,
    input  logic [AddrWidth-1:0]   data_addr_i,
    input  logic [DataWidth-1:0]   data_wdata_i,
    output logic                   data_gnt_o,
    output logic                   data_rvalid_o,
    output logic [DataWidth-1:0]   data_rdata_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    input  logic [DataWidth-1:0]   mem_rdata_i
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]            perf_conflict_o,
    output logic [31:0]            perf_starve_o
`endif
);

    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned CntW    = 4;
    localparam logic [CntW-1:0] StarveMax = CntW'(StarveLimit);

    // One-hot owner encoding so each rvalid is a flop bit.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'b00,
        OWN_INSTR = 2'b01,
        OWN_DATA  = 2'b10
    } owner_e;

    typedef enum logic {
        HOST_INSTR = 1'b0,
        HOST_DATA  = 1'b1
    } host_e;

    owner_e          owner_q;
    host_e           last_q;
    logic [CntW-1:0] starve_cnt_q;

    logic w_conflict;
    logic w_starved;
    logic w_instr_wins;
    logic w_instr_gnt;
    logic w_data_gnt;

    assign w_conflict = instr_req_i & data_req_i;
    assign w_starved  = (starve_cnt_q == StarveMax);

    // Conflict winner: alternate in round-robin mode, otherwise data unless starved.
    always_comb begin
        w_instr_wins = 1'b0;
        if (RoundRobin != 0) begin
            w_instr_wins = (last_q == HOST_DATA);
        end else begin
            w_instr_wins = w_starved;
        end
    end

    assign w_instr_gnt = instr_req_i & (~w_conflict | w_instr_wins);
    assign w_data_gnt  = data_req_i & ~w_instr_gnt;

    assign instr_gnt_o = w_instr_gnt;
    assign data_gnt_o  = w_data_gnt;
    assign mem_req_o   = w_instr_gnt | w_data_gnt;

    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (w_instr_gnt) begin
            mem_be_o   = {BeWidth{1'b1}};
            mem_addr_o = instr_addr_i;
        end else if (w_data_gnt) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q      <= OWN_NONE;
            last_q       <= HOST_DATA;
            starve_cnt_q <= '0;
        end else begin
            if (w_instr_gnt) begin
                owner_q <= OWN_INSTR;
                last_q  <= HOST_INSTR;
            end else if (w_data_gnt) begin
                owner_q <= OWN_DATA;
                last_q  <= HOST_DATA;
            end else begin
                owner_q <= OWN_NONE;
            end

            if (!instr_req_i || w_instr_gnt) begin
                starve_cnt_q <= '0;
            end else if (!w_starved) begin
                starve_cnt_q <= starve_cnt_q + CntW'(1);
            end
        end
    end

    // RAM read data is broadcast; each host qualifies it with its own rvalid.
    assign instr_rvalid_o = owner_q[0];
    assign data_rvalid_o  = owner_q[1];
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_perf_conflict;
    logic [31:0] r_perf_starve;
    logic        w_forced_win;

    assign w_forced_win = w_conflict & w_starved & (RoundRobin == 0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_conflict <= '0;
            r_perf_starve   <= '0;
        end else begin
            if (w_conflict) begin
                r_perf_conflict <= r_perf_conflict + 32'd1;
            end
            if (w_forced_win) begin
                r_perf_starve <= r_perf_starve + 32'd1;
            end
        end
    end

    assign perf_conflict_o = r_perf_conflict;
    assign perf_starve_o   = r_perf_starve;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a fixed-priority and a round-robin instance, each with
// a behavioural RAM, checked by per-cycle vectors and a response scoreboard.
module tb_mem_port_arbiter;

    localparam logic [31:0] RrKey   = 32'hC0DE_0000;
    localparam logic [31:0] RrIAddr = 32'h0000_0040;
    localparam logic [31:0] RrDAddr = 32'h0000_0080;

    typedef struct packed {
        logic        rst;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        eig;
        logic        edg;
        logic        rr_ireq;
        logic        rr_dreq;
        logic        rr_eig;
        logic        rr_edg;
    } vec_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic        is_instr;
        logic        chk_data;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic [31:0] cyc = 32'd0;
    logic        rst, mon_en, ram_load;
    int          n_chk = 0;
    int          n_fail = 0;

    logic        ireq, dreq, dwe;
    logic [31:0] iaddr, daddr, dwdata;
    logic [3:0]  dbe;
    logic        ig, iv, dg, dv;
    logic [31:0] irdata, drdata;
    logic        mreq, mwe;
    logic [3:0]  mbe;
    logic [31:0] maddr, mwdata, mrdata;

    logic        rr_ireq, rr_dreq;
    logic [31:0] rr_iaddr, rr_daddr;
    logic        rr_ig, rr_iv, rr_dg, rr_dv;
    logic [31:0] rr_irdata, rr_drdata;
    logic        rr_mreq, rr_mwe;
    logic [3:0]  rr_mbe;
    logic [31:0] rr_maddr, rr_mwdata, rr_mrdata;

    logic [31:0] ram [256];
    logic [31:0] shadow [256];
    resp_t       fq [$];
    resp_t       rq [$];
    resp_t       fr, rr_r;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_conflict, perf_starve, rr_perf_conflict, rr_perf_starve;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    mem_port_arbiter #(.AddrWidth(32), .DataWidth(32), .RoundRobin(0), .StarveLimit(4)) u_fix (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(ireq), .instr_addr_i(iaddr), .instr_gnt_o(ig),
        .instr_rvalid_o(iv), .instr_rdata_o(irdata),
        .data_req_i(dreq), .data_we_i(dwe), .data_be_i(dbe), .data_addr_i(daddr),
        .data_wdata_i(dwdata), .data_gnt_o(dg), .data_rvalid_o(dv), .data_rdata_o(drdata),
        .mem_req_o(mreq), .mem_we_o(mwe), .mem_be_o(mbe), .mem_addr_o(maddr),
        .mem_wdata_o(mwdata), .mem_rdata_i(mrdata)
`ifdef MEM_ARB_PERF_EN
        , .perf_conflict_o(perf_conflict), .perf_starve_o(perf_starve)
`endif
    );

    mem_port_arbiter #(.AddrWidth(32), .DataWidth(32), .RoundRobin(1), .StarveLimit(4)) u_rr (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(rr_ireq), .instr_addr_i(rr_iaddr), .instr_gnt_o(rr_ig),
        .instr_rvalid_o(rr_iv), .instr_rdata_o(rr_irdata),
        .data_req_i(rr_dreq), .data_we_i(1'b0), .data_be_i(4'hF), .data_addr_i(rr_daddr),
        .data_wdata_i(32'd0), .data_gnt_o(rr_dg), .data_rvalid_o(rr_dv), .data_rdata_o(rr_drdata),
        .mem_req_o(rr_mreq), .mem_we_o(rr_mwe), .mem_be_o(rr_mbe), .mem_addr_o(rr_maddr),
        .mem_wdata_o(rr_mwdata), .mem_rdata_i(rr_mrdata)
`ifdef MEM_ARB_PERF_EN
        , .perf_conflict_o(rr_perf_conflict), .perf_starve_o(rr_perf_starve)
`endif
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 64) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(i);
    endfunction

    // Behavioural single-port RAM with one cycle read latency.
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        end else if (mreq) begin
            if (mwe) begin
                for (int b = 0; b < 4; b++)
                    if (mbe[b]) ram[maddr[9:2]][8*b +: 8] <= mwdata[8*b +: 8];
            end else begin
                mrdata <= ram[maddr[9:2]];
            end
        end
    end

    always @(posedge clk) rr_mrdata <= rr_maddr ^ RrKey;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h (t=%0t)", nm, act, want, $time);
        end
    endtask

    function automatic vec_t fx(input logic ir, input logic [31:0] ia, input logic dr,
                                input logic we, input logic [3:0] be, input logic [31:0] da,
                                input logic [31:0] wd, input logic eig, input logic edg);
        vec_t v = '0;
        v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dwe = we; v.dbe = be;
        v.daddr = da; v.dwdata = wd; v.eig = eig; v.edg = edg;
        return v;
    endfunction

    function automatic vec_t rrv(input logic ri, input logic rd, input logic eig, input logic edg);
        vec_t v = '0;
        v.rr_ireq = ri; v.rr_dreq = rd; v.rr_eig = eig; v.rr_edg = edg;
        return v;
    endfunction

    function automatic resp_t mk(input logic [31:0] c, input logic is_i, input logic cd,
                                 input logic [31:0] d);
        resp_t r;
        r.cyc = c; r.is_instr = is_i; r.chk_data = cd; r.data = d;
        return r;
    endfunction

    // Drive one cycle, check grants and RAM request, push expected responses.
    task automatic step(input vec_t v);
        logic [31:0] ea, ewd;
        logic        ewe;
        logic [3:0]  ebe;
        rst = v.rst; ireq = v.ireq; iaddr = v.iaddr; dreq = v.dreq; dwe = v.dwe;
        dbe = v.dbe; daddr = v.daddr; dwdata = v.dwdata;
        rr_ireq = v.rr_ireq; rr_dreq = v.rr_dreq;
        ea = '0; ewd = '0; ewe = 1'b0; ebe = '0;
        if (v.eig) begin
            ea = v.iaddr; ebe = 4'hF;
        end else if (v.edg) begin
            ea = v.daddr; ewe = v.dwe; ebe = v.dbe; ewd = v.dwdata;
        end
        @(negedge clk);
        chk("instr_gnt", 32'(ig), 32'(v.eig));
        chk("data_gnt", 32'(dg), 32'(v.edg));
        chk("mem_req", 32'(mreq), 32'(v.eig | v.edg));
        chk("mem_addr", maddr, ea);
        chk("mem_we", 32'(mwe), 32'(ewe));
        chk("mem_be", 32'(mbe), 32'(ebe));
        chk("mem_wdata", mwdata, ewd);
        chk("rr_instr_gnt", 32'(rr_ig), 32'(v.rr_eig));
        chk("rr_data_gnt", 32'(rr_dg), 32'(v.rr_edg));
        chk("rr_mem_we", 32'(rr_mwe), 32'd0);
        if (!v.rst) begin
            if (v.eig) fq.push_back(mk(cyc + 1, 1'b1, 1'b1, shadow[v.iaddr[9:2]]));
            else if (v.edg) fq.push_back(mk(cyc + 1, 1'b0, !v.dwe, shadow[v.daddr[9:2]]));
            if (v.rr_eig) rq.push_back(mk(cyc + 1, 1'b1, 1'b1, RrIAddr ^ RrKey));
            else if (v.rr_edg) rq.push_back(mk(cyc + 1, 1'b0, 1'b1, RrDAddr ^ RrKey));
        end
        if (v.edg && v.dwe) begin
            for (int b = 0; b < 4; b++)
                if (v.dbe[b]) shadow[v.daddr[9:2]][8*b +: 8] = v.dwdata[8*b +: 8];
        end
        @(posedge clk);
        #1;
    endtask

    // Response scoreboard: rvalid must appear exactly in the cycle recorded at grant.
    always @(negedge clk) begin
        if (mon_en) begin
            if (fq.size() > 0 && fq[0].cyc == cyc) begin
                fr = fq.pop_front();
                chk("fix_instr_rvalid", 32'(iv), 32'(fr.is_instr));
                chk("fix_data_rvalid", 32'(dv), 32'(!fr.is_instr));
                if (fr.chk_data)
                    chk(fr.is_instr ? "fix_instr_rdata" : "fix_data_rdata",
                        fr.is_instr ? irdata : drdata, fr.data);
            end else begin
                chk("fix_idle_instr_rvalid", 32'(iv), 32'd0);
                chk("fix_idle_data_rvalid", 32'(dv), 32'd0);
            end
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
                rr_r = rq.pop_front();
                chk("rr_instr_rvalid", 32'(rr_iv), 32'(rr_r.is_instr));
                chk("rr_data_rvalid", 32'(rr_dv), 32'(!rr_r.is_instr));
                chk(rr_r.is_instr ? "rr_instr_rdata" : "rr_data_rdata",
                    rr_r.is_instr ? rr_irdata : rr_drdata, rr_r.data);
            end else begin
                chk("rr_idle_instr_rvalid", 32'(rr_iv), 32'd0);
                chk("rr_idle_data_rvalid", 32'(rr_dv), 32'd0);
            end
        end
    end

    vec_t tbl [11];
    vec_t rst_v;

    initial begin
        rst = 1'b1; ram_load = 1'b1; mon_en = 1'b0;
        ireq = 0; dreq = 0; dwe = 0; dbe = 0; iaddr = 0; daddr = 0; dwdata = 0;
        rr_ireq = 0; rr_dreq = 0; rr_iaddr = RrIAddr; rr_daddr = RrDAddr;
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        rst_v = '0;
        rst_v.rst = 1'b1;

        tbl[0]  = fx(1, 32'h100, 0, 0, 4'h0,    32'h0,   32'h0,         1, 0);
        tbl[1]  = fx(0, 32'h0,   1, 1, 4'b0011, 32'h200, 32'h1234_5678, 0, 1);
        tbl[2]  = fx(0, 32'h0,   0, 0, 4'h0,    32'h0,   32'h0,         0, 0);
        tbl[3]  = fx(1, 32'h200, 0, 0, 4'h0,    32'h0,   32'h0,         1, 0);
        tbl[4]  = fx(0, 32'h0,   1, 0, 4'hF,    32'h100, 32'h0,         0, 1);
        tbl[5]  = fx(1, 32'h104, 1, 0, 4'hF,    32'h200, 32'h0,         0, 1);
        tbl[6]  = fx(1, 32'h104, 0, 0, 4'h0,    32'h0,   32'h0,         1, 0);
        tbl[7]  = fx(0, 32'h0,   1, 1, 4'hF,    32'h104, 32'hCAFE_F00D, 0, 1);
        tbl[8]  = fx(1, 32'h104, 0, 0, 4'h0,    32'h0,   32'h0,         1, 0);
        tbl[9]  = fx(1, 32'h104, 1, 1, 4'b1100, 32'h108, 32'hAABB_CCDD, 0, 1);
        tbl[10] = fx(1, 32'h108, 0, 0, 4'h0,    32'h0,   32'h0,         1, 0);

        @(posedge clk); #1;
        ram_load = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_instr_rvalid", 32'(iv), 32'd0);
        chk("reset_data_rvalid", 32'(dv), 32'd0);
        chk("reset_rr_instr_rvalid", 32'(rr_iv), 32'd0);
        chk("reset_rr_data_rvalid", 32'(rr_dv), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) step(tbl[i]);
        step(fx(0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("ram_byte_write", shadow[128], 32'h1000_5678);

        // Continuous conflict from reset: data wins four cycles, then instr is forced.
        step(rst_v);
        for (int i = 0; i < 10; i++)
            step(fx(1, 32'h100, 1, 0, 4'hF, 32'h200, 32'h0, (i % 5) == 4, (i % 5) != 4));
        step(fx(0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef MEM_ARB_PERF_EN
        chk("perf_conflict", perf_conflict, 32'd10);
        chk("perf_starve", perf_starve, 32'd2);
`endif

        // Reset right after a data read grant; the grant inside reset is dropped.
        step(fx(0, 0, 1, 0, 4'hF, 32'h100, 0, 0, 1));
        rst_v.ireq = 1'b1; rst_v.iaddr = 32'h104; rst_v.eig = 1'b1;
        step(rst_v);
        step(fx(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(fx(0, 0, 1, 0, 4'hF, 32'h104, 0, 0, 1));
        step(fx(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Round-robin: alternate from reset (instr first), lone grants update the pointer.
        for (int i = 0; i < 6; i++) step(rrv(1, 1, (i % 2) == 0, (i % 2) == 1));
        step(rrv(0, 1, 0, 1));
        step(rrv(1, 1, 1, 0));
        step(rrv(1, 1, 0, 1));
        step(rrv(0, 0, 0, 0));
        step(rrv(0, 0, 0, 0));

        chk("fix_queue_drained", 32'(fq.size()), 32'd0);
        chk("rr_queue_drained", 32'(rq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port RAM (fixed 1-cycle read latency) between the core instruction-fetch port and the data bus RAM device port.
- Sits between the core/bus and the RAM. Replaces the dual-port RAM arrangement so designs can target single-port memories.
- Uses the req/gnt/rvalid protocol: grant is combinational in the request cycle; rvalid/rdata follow one cycle later.
- Arbitration is fixed data-priority with instruction anti-starvation, or round-robin, selected by parameter.

Parameters:
- AddrWidth, 32, address width of all ports.
- DataWidth, 32, data width; byte-enable width is DataWidth/8.
- RoundRobin, 0, 0 = data priority plus starvation guard; 1 = alternate on conflict.
- StarveLimit, 4, consecutive denied instr cycles before instr is forced to win (fixed mode only); range 1..15.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  AddrWidth  fetch byte address
- instr_gnt_o  out  1  fetch granted this cycle
- instr_rvalid_o  out  1  fetch data valid
- instr_rdata_o  out  DataWidth  fetch data
- data_req_i  in  1  data request
- data_we_i  in  1  write enable
- data_be_i  in  DataWidth/8  byte enables
- data_addr_i  in  AddrWidth  data byte address
- data_wdata_i  in  DataWidth  write data
- data_gnt_o  out  1  data granted this cycle
- data_rvalid_o  out  1  data response valid (reads and writes)
- data_rdata_o  out  DataWidth  read data
- mem_req_o  out  1  RAM request
- mem_we_o  out  1  RAM write enable
- mem_be_o  out  DataWidth/8  RAM byte enables
- mem_addr_o  out  AddrWidth  RAM address
- mem_wdata_o  out  DataWidth  RAM write data
- mem_rdata_i  in  DataWidth  RAM read data, valid the cycle after mem_req_o

Behaviour:
- One clock; reset is synchronous and active-high (clk_i, rst_i).
- Grant logic (combinational):
  - At most one of instr_gnt_o / data_gnt_o is high per cycle.
  - A lone requester is always granted.
  - mem_req_o = instr_gnt_o | data_gnt_o.
- RAM mux:
  - mem_addr_o/we/be/wdata come from the granted host.
  - An instr grant forces we=0, be=all ones, wdata=0.
  - With no grant, mem outputs are 0.
- Conflict (both requesting), fixed mode:
  - data wins unless starve_cnt_q == StarveLimit, in which case instr wins.
  - starve_cnt_q: increments (saturating at StarveLimit) on cycles with instr_req_i & ~instr_gnt_o. Clears on instr grant or when instr_req_i is low.
- Conflict, round-robin mode:
  - Winner is the host not in last_q. last_q updates to the granted host on every grant. Reset value of last_q is data, so instr wins the first conflict.
- Response routing:
  - owner_q (states NONE/INSTR/DATA) is registered from the grant.
  - Next cycle: instr_rvalid_o = (owner_q==INSTR) and data_rvalid_o = (owner_q==DATA).
  - instr_rdata_o = data_rdata_o = mem_rdata_i (broadcast; qualified by rvalid).
  - A data write still returns data_rvalid_o one cycle after grant.
- Throughput: back-to-back grants every cycle; no bubbles. Request held with no grant means the host keeps it stable (protocol rule, not checked).
- Reset:
  - Sync reset clears owner_q to NONE, starve_cnt_q to 0 and last_q to data.
  - Both rvalids are 0 in the cycle after a reset cycle, even if a grant occurred during the reset cycle.
  - Grants remain combinational during reset; the RAM may execute them, but their responses are dropped.
- Reset values of registered outputs: instr_rvalid_o=0, data_rvalid_o=0.

Optional Feature:
- Macro MEM_ARB_PERF_EN. When defined, adds outputs:
  - perf_conflict_o (32): counts cycles with both requests high.
  - perf_starve_o (32): counts cycles where the starvation guard forced an instr win.
- Both counters are synchronous-reset to 0 and wrap at 2^32.
- Without the macro, these ports and counters do not exist and the behaviour above is unchanged.

Test Plan:
- Instr-only read of 0x100 holding 0xDEADBEEF -> instr_gnt_o=1 same cycle; next cycle instr_rvalid_o=1, instr_rdata_o=0xDEADBEEF, data_rvalid_o=0.
- Data write 0x200 = 0x12345678 with be=4'b0011, then instr read 0x200 -> data_rvalid_o one cycle after grant; later fetch returns 0xXXXX5678 with the upper bytes unchanged.
- Fixed mode, StarveLimit=4, both requesting continuously -> data granted for 4 cycles, instr on the 5th; pattern repeats every 5 cycles; instr never waits more than 4 cycles.
- RoundRobin=1, both requesting continuously from reset -> grants alternate I,D,I,D; each rvalid arrives exactly one cycle after its grant on the correct host.
- Assert rst_i in the cycle after a data read grant -> data_rvalid_o=0 in the cycle after the reset cycle; owner_q=NONE; next request proceeds normally.
- With MEM_ARB_PERF_EN in fixed mode, 10 cycles of dual request -> perf_conflict_o=10, perf_starve_o=2.
